uart_rx: RTL and testbench

//  UART receiver; receive-side counterpart of the motor-link UART transmitter. Samples the async

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_sync.sv | 24 ++
 rtl/uart_rx.sv | 167 ++++++++++++++++
 tb/tb_uart_rx.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encoding, parity modes and sampling helper
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
        PARITY_BIT,
        STOP_BIT
    } uart_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchroniser with configurable reset value
module uart_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic meta;

    // Two-stage capture of the asynchronous line; reset to the idle level.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RESET_VAL;
            dout <= RESET_VAL;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver with valid/ready output; UART_RX_MAJORITY_EN selects 3-sample majority voting
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 50_000_000 / 115_200,
    parameter int BITS_N       = 8,
    parameter int PARITY_TYPE  = PARITY_NONE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_in,
    output logic [BITS_N-1:0] data_rx,
    output logic              valid,
    input  logic              ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun
);

    localparam int CW   = $clog2(CLKS_PER_BIT + 1);
    localparam int BW   = (BITS_N > 1) ? $clog2(BITS_N) : 1;
    localparam int HALF = CLKS_PER_BIT / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int START_DEC = HALF + 1;
`else
    localparam int START_DEC = HALF - 1;
`endif
    localparam logic [CW-1:0] START_DEC_C = CW'(START_DEC);
    localparam logic [CW-1:0] BIT_DEC_C   = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT    = BW'(BITS_N - 1);

    uart_state_t       state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [BW-1:0]     bit_n, bit_n_n;
    logic [BITS_N-1:0] shreg, shreg_n;
    logic              perr, perr_n;
    logic              deliver;
    logic              stop_ferr;
    logic              rx_s;
    logic              samp;
    logic              exp_par;

    uart_rx_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (uart_in),
        .dout (rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    logic rx_d1, rx_d2;

    // History of the two previous synchronised samples for the majority vote.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_d1 <= 1'b1;
            rx_d2 <= 1'b1;
        end else begin
            rx_d1 <= rx_s;
            rx_d2 <= rx_d1;
        end
    end

    assign samp = majority3(rx_s, rx_d1, rx_d2);
`else
    assign samp = rx_s;
`endif

    assign exp_par = (PARITY_TYPE == PARITY_ODD) ? ~^shreg : ^shreg;

    // Frame sequencing: bit timing, data assembly, parity and stop checks.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt + CW'(1);
        bit_n_n   = bit_n;
        shreg_n   = shreg;
        perr_n    = perr;
        deliver   = 1'b0;
        stop_ferr = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rx_s) begin
                    state_n = START_BIT;
                    perr_n  = 1'b0;
                end
            end
            START_BIT: begin
                if (cnt == START_DEC_C) begin
                    cnt_n   = '0;
                    bit_n_n = '0;
                    state_n = samp ? IDLE : DATA_BITS;
                end
            end
            DATA_BITS: begin
                if (cnt == BIT_DEC_C) begin
                    cnt_n   = '0;
                    shreg_n = {samp, shreg[BITS_N-1:1]};
                    if (bit_n == LAST_BIT) begin
                        state_n = (PARITY_TYPE != PARITY_NONE) ? PARITY_BIT : STOP_BIT;
                    end else begin
                        bit_n_n = bit_n + BW'(1);
                    end
                end
            end
            PARITY_BIT: begin
                if (cnt == BIT_DEC_C) begin
                    cnt_n   = '0;
                    perr_n  = (samp != exp_par);
                    state_n = STOP_BIT;
                end
            end
            STOP_BIT: begin
                if (cnt == BIT_DEC_C) begin
                    cnt_n     = '0;
                    stop_ferr = ~samp;
                    deliver   = 1'b1;
                    state_n   = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // FSM, counter and shift register state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            bit_n <= '0;
            shreg <= '0;
            perr  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            bit_n <= bit_n_n;
            shreg <= shreg_n;
            perr  <= perr_n;
        end
    end

    // Output word register: load when free or being consumed, else flag overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_rx    <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (deliver) begin
                if (!valid || ready) begin
                    data_rx    <= shreg;
                    parity_err <= perr;
                    frame_err  <= stop_ferr;
                    valid      <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx (three parity variants)
`timescale 1ns/1ps
module tb_uart_rx;

    localparam realtime BT = 80.0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic line = 1'b1;
    logic rdy0 = 1'b1, rdy1 = 1'b1, rdy2 = 1'b1;
    logic [7:0] d0, d1, d2;
    logic v0, v1, v2, pe0, pe1, pe2, fe0, fe1, fe2, ov0, ov1, ov2;

    int checks = 0;
    int failures = 0;
    logic [9:0] q0[$], q1[$], q2[$];
    int vc0 = 0, oc0 = 0;

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(8), .BITS_N(8), .PARITY_TYPE(0)) dut0 (
        .clk(clk), .rst(rst), .uart_in(line), .data_rx(d0), .valid(v0), .ready(rdy0),
        .parity_err(pe0), .frame_err(fe0), .overrun(ov0));
    uart_rx #(.CLKS_PER_BIT(8), .BITS_N(8), .PARITY_TYPE(1)) dut1 (
        .clk(clk), .rst(rst), .uart_in(line), .data_rx(d1), .valid(v1), .ready(rdy1),
        .parity_err(pe1), .frame_err(fe1), .overrun(ov1));
    uart_rx #(.CLKS_PER_BIT(8), .BITS_N(8), .PARITY_TYPE(2)) dut2 (
        .clk(clk), .rst(rst), .uart_in(line), .data_rx(d2), .valid(v2), .ready(rdy2),
        .parity_err(pe2), .frame_err(fe2), .overrun(ov2));

    always @(negedge clk) begin
        if (v0 && rdy0) q0.push_back({pe0, fe0, d0});
        if (v1 && rdy1) q1.push_back({pe1, fe1, d1});
        if (v2 && rdy2) q2.push_back({pe2, fe2, d2});
        if (v0) vc0++;
        if (ov0) oc0++;
    end

    // par: -1 no parity bit, else parity bit value; gbit: bit index to glitch at mid-bit, -1 none
    task automatic send(input logic [7:0] d, input int par, input logic stop,
                        input realtime bt, input int gbit);
        logic bits[11];
        int n;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        n = 9;
        if (par >= 0) begin
            bits[n] = par[0];
            n++;
        end
        bits[n] = stop;
        n++;
        for (int k = 0; k < n; k++) begin
            line = bits[k];
            if (k == gbit) begin
                #(bt / 2);
                line = ~bits[k];
                #10;
                line = bits[k];
                #(bt / 2 - 10);
            end else begin
                #(bt);
            end
        end
        line = 1'b1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        line = 1'b1;
        rst = 1'b1;
        rdy0 = 1'b1; rdy1 = 1'b1; rdy2 = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++; if (v0 !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", v0); end
        checks++; if (d0 !== 8'h00) begin failures++; $display("FAIL reset_data got=%h want=00", d0); end
        checks++; if (pe0 !== 1'b0) begin failures++; $display("FAIL reset_perr got=%b want=0", pe0); end
        checks++; if (fe0 !== 1'b0) begin failures++; $display("FAIL reset_ferr got=%b want=0", fe0); end
        checks++; if (ov0 !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b want=0", ov0); end
    endtask

    task automatic test_no_parity();
        int n, vb;
        do_reset();
        n = q0.size(); vb = vc0;
        send(8'hA5, -1, 1'b1, BT, -1);
        #(BT);
        checks++;
        if (q0.size() != n + 1) begin
            failures++; $display("FAIL t1_count got=%0d want=%0d", q0.size() - n, 1);
        end else begin
            checks++;
            if (q0[n] !== {2'b00, 8'hA5}) begin failures++; $display("FAIL t1_word got=%h want=%h", q0[n], {2'b00, 8'hA5}); end
        end
        checks++; if (vc0 - vb != 1) begin failures++; $display("FAIL t1_valid_cycles got=%0d want=1", vc0 - vb); end
    endtask

    task automatic test_odd_parity();
        int n;
        do_reset();
        n = q1.size();
        send(8'h03, 1, 1'b1, BT, -1);
        #(BT);
        send(8'h03, 0, 1'b1, BT, -1);
        #(BT);
        checks++;
        if (q1.size() != n + 2) begin
            failures++; $display("FAIL t2_count got=%0d want=2", q1.size() - n);
        end else begin
            checks++;
            if (q1[n] !== {2'b00, 8'h03}) begin failures++; $display("FAIL t2_good got=%h want=%h", q1[n], {2'b00, 8'h03}); end
            checks++;
            if (q1[n+1] !== {2'b10, 8'h03}) begin failures++; $display("FAIL t2_bad got=%h want=%h", q1[n+1], {2'b10, 8'h03}); end
        end
    endtask

    task automatic test_even_frame_err();
        int n;
        do_reset();
        n = q2.size();
        send(8'h55, 0, 1'b0, BT, -1);
        #(BT * 2);
        checks++;
        if (q2.size() != n + 1) begin
            failures++; $display("FAIL t3_count got=%0d want=1", q2.size() - n);
        end else begin
            checks++;
            if (q2[n] !== {2'b01, 8'h55}) begin failures++; $display("FAIL t3_word got=%h want=%h", q2[n], {2'b01, 8'h55}); end
        end
    endtask

    task automatic test_overrun();
        int n, ob;
        do_reset();
        @(posedge clk); #1 rdy0 = 1'b0;
        n = q0.size(); ob = oc0;
        send(8'h11, -1, 1'b1, BT, -1);
        send(8'h22, -1, 1'b1, BT, -1);
        #(BT);
        @(negedge clk);
        checks++; if (v0 !== 1'b1) begin failures++; $display("FAIL t4_valid_held got=%b want=1", v0); end
        checks++; if (d0 !== 8'h11) begin failures++; $display("FAIL t4_data_held got=%h want=11", d0); end
        checks++; if (oc0 - ob != 1) begin failures++; $display("FAIL t4_overrun got=%0d want=1", oc0 - ob); end
        @(posedge clk); #1 rdy0 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (v0 !== 1'b0) begin failures++; $display("FAIL t4_valid_drop got=%b want=0", v0); end
        checks++;
        if (q0.size() != n + 1) begin failures++; $display("FAIL t4_accepted got=%0d want=1", q0.size() - n); end
        else begin
            checks++;
            if (q0[n] !== {2'b00, 8'h11}) begin failures++; $display("FAIL t4_word got=%h want=%h", q0[n], {2'b00, 8'h11}); end
        end
    endtask

    task automatic test_glitch();
        int n;
        do_reset();
        n = q0.size();
        line = 1'b0;
        #30;
        line = 1'b1;
        #(BT * 2);
        checks++; if (q0.size() != n) begin failures++; $display("FAIL t5_glitch_word got=%0d want=0", q0.size() - n); end
        send(8'h7E, -1, 1'b1, BT, -1);
        #(BT);
        checks++;
        if (q0.size() != n + 1) begin failures++; $display("FAIL t5_count got=%0d want=1", q0.size() - n); end
        else begin
            checks++;
            if (q0[n] !== {2'b00, 8'h7E}) begin failures++; $display("FAIL t5_word got=%h want=%h", q0[n], {2'b00, 8'h7E}); end
        end
    endtask

    task automatic test_reset_midframe();
        int n;
        do_reset();
        @(posedge clk); #1 rdy0 = 1'b0;
        send(8'h5A, -1, 1'b1, BT, -1);
        #(BT);
        @(negedge clk);
        checks++; if (v0 !== 1'b1 || d0 !== 8'h5A) begin failures++; $display("FAIL t6_pending got=%b/%h want=1/5a", v0, d0); end
        fork
            send(8'hFF, -1, 1'b1, BT, -1);
            begin
                #(BT * 5.5);
                @(posedge clk); #1 rst = 1'b1;
                @(posedge clk); #1 rst = 1'b0;
            end
        join
        @(negedge clk);
        checks++; if (v0 !== 1'b0 || d0 !== 8'h00) begin failures++; $display("FAIL t6_after_rst got=%b/%h want=0/00", v0, d0); end
        @(posedge clk); #1 rdy0 = 1'b1;
        n = q0.size();
        send(8'h0F, -1, 1'b1, BT, -1);
        #(BT);
        checks++;
        if (q0.size() != n + 1) begin failures++; $display("FAIL t6_count got=%0d want=1", q0.size() - n); end
        else begin
            checks++;
            if (q0[n] !== {2'b00, 8'h0F}) begin failures++; $display("FAIL t6_word got=%h want=%h", q0[n], {2'b00, 8'h0F}); end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [7:0] exp_w[5];
        exp_w = '{8'h01, 8'h80, 8'hF0, 8'h3C, 8'hC3};
        do_reset();
        n = q0.size();
        send(exp_w[0], -1, 1'b1, BT, -1);
        send(exp_w[1], -1, 1'b1, BT, -1);
        send(exp_w[2], -1, 1'b1, BT, -1);
        #(BT);
        send(exp_w[3], -1, 1'b1, BT * 0.97, -1);
        #(BT);
        send(exp_w[4], -1, 1'b1, BT * 1.03, -1);
        #(BT);
        checks++;
        if (q0.size() != n + 5) begin failures++; $display("FAIL b2b_count got=%0d want=5", q0.size() - n); end
        else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (q0[n+i] !== {2'b00, exp_w[i]}) begin
                    failures++; $display("FAIL b2b_word%0d got=%h want=%h", i, q0[n+i], {2'b00, exp_w[i]});
                end
            end
        end
    endtask

`ifdef UART_RX_MAJORITY_EN
    task automatic test_majority_glitch();
        int n;
        do_reset();
        n = q0.size();
        @(posedge clk); #2;
        send(8'h00, -1, 1'b1, BT, 4);
        #(BT);
        @(posedge clk); #2;
        send(8'hFF, -1, 1'b1, BT, 6);
        #(BT);
        checks++;
        if (q0.size() != n + 2) begin failures++; $display("FAIL maj_count got=%0d want=2", q0.size() - n); end
        else begin
            checks++;
            if (q0[n] !== {2'b00, 8'h00}) begin failures++; $display("FAIL maj_word0 got=%h want=%h", q0[n], {2'b00, 8'h00}); end
            checks++;
            if (q0[n+1] !== {2'b00, 8'hFF}) begin failures++; $display("FAIL maj_word1 got=%h want=%h", q0[n+1], {2'b00, 8'hFF}); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_no_parity();
        test_odd_parity();
        test_even_frame_err();
        test_overrun();
        test_glitch();
        test_reset_midframe();
        test_back_to_back();
`ifdef UART_RX_MAJORITY_EN
        test_majority_glitch();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
